// File: rtl/stream_demux2.sv
// Packet-level 1:2 stream demultiplexer with a one-entry registered buffer per output.
// Define STREAM_DEMUX2_CNT_EN to add the per-output packet counters pkt_cnt0/pkt_cnt1.
module stream_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             active_sel,
    output logic             busy
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    state_t state, state_next;
    logic   dest;
    logic   can0, can1;
    logic   xfer;

    // in_ready looks only at the destination buffer, so a stalled idle output never blocks the other.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dest       = in_sel;
        state_next = state;
        case (state)
            ROUTE0:  dest = 1'b0;
            ROUTE1:  dest = 1'b1;
            default: dest = in_sel;
        endcase
        can0     = !out0_valid || out0_ready;
        can1     = !out1_valid || out1_ready;
        in_ready = dest ? can1 : can0;
        xfer     = in_valid && in_ready;
        if (xfer) begin
            if (in_last) state_next = IDLE;
            else         state_next = dest ? ROUTE1 : ROUTE0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out0_last  <= 1'b0;
        end else if (xfer && !dest) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
            out0_last  <= in_last;
        end else if (out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            out1_last  <= 1'b0;
        end else if (xfer && dest) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
            out1_last  <= in_last;
        end else if (out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

    assign active_sel = (state == ROUTE1);
    assign busy       = (state != IDLE);

`ifdef STREAM_DEMUX2_CNT_EN
    // A packet is counted when its last beat leaves the output buffer; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready && out0_last) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (out1_valid && out1_ready && out1_last) pkt_cnt1 <= pkt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Scoreboard bench for stream_demux2: the driver queues each accepted beat for its
// hand-chosen output, a negedge monitor compares every output pop against the queue.
module tb_stream_demux2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_sel = 1'b0;
    logic       out0_valid, out1_valid;
    logic       out0_ready = 1'b1;
    logic       out1_ready = 1'b1;
    logic [7:0] out0_data, out1_data;
    logic       out0_last, out1_last;
    logic       active_sel, busy;
`ifdef STREAM_DEMUX2_CNT_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

    stream_demux2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .active_sel (active_sel),
        .busy       (busy)
`ifdef STREAM_DEMUX2_CNT_EN
        ,
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per output pop, plus hold-stability while stalled.
    logic       hold0 = 1'b0, hold1 = 1'b0;
    logic [8:0] prev0 = '0, prev1 = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (hold0 && out0_valid) check("out0_stable", {out0_last, out0_data}, prev0);
            if (hold1 && out1_valid) check("out1_stable", {out1_last, out1_data}, prev1);
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out0_unexpected: got %0h expected none", {out0_last, out0_data});
                end else check("out0_pop", {out0_last, out0_data}, exp0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out1_unexpected: got %0h expected none", {out1_last, out1_data});
                end else check("out1_pop", {out1_last, out1_data}, exp1.pop_front());
            end
        end
        hold0 = out0_valid && !out0_ready;
        hold1 = out1_valid && !out1_ready;
        prev0 = {out0_last, out0_data};
        prev1 = {out1_last, out1_data};
    end

    // Drive one beat until accepted; dest is the output the bench expects it on.
    task automatic send(input logic [7:0] data, input logic last, input logic sel,
                        input logic dest, output int waits);
        logic ok;
        ok       = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        in_sel   = sel;
        while (!ok && waits < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else          waits++;
        end
        if (ok) begin
            if (dest) exp1.push_back({last, data});
            else      exp0.push_back({last, data});
        end else begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got no in_ready expected accept of %0h", data);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (ok) begin
            if (dest) check("latency_out1", {out1_valid, out1_last, out1_data}, {1'b1, last, data});
            else      check("latency_out0", {out0_valid, out0_last, out0_data}, {1'b1, last, data});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int prev_acc;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", {out0_valid, out1_valid}, 2'b00);
        check("rst_data",  {out0_last, out0_data, out1_last, out1_data}, 18'h0);
        check("rst_state", {busy, active_sel}, 2'b00);
        check("rst_in_ready", in_ready, 1'b1);

        // Throughput: alternating single-beat packets, one acceptance per cycle.
        for (int i = 0; i < 8; i++) begin
            send(8'(i), 1'b1, i[0], i[0], w);
            check("thru_waits", w, 0);
            if (i > 0) check("thru_cycle", acc_cyc, prev_acc + 1);
            prev_acc = acc_cyc;
        end
        repeat (2) @(posedge clk);
        #1;
`ifdef STREAM_DEMUX2_CNT_EN
        check("cnt0_after_thru", pkt_cnt0, 16'd4);
        check("cnt1_after_thru", pkt_cnt1, 16'd4);
        force dut.pkt_cnt0 = 16'hFFFF;
        @(posedge clk);
        #1 release dut.pkt_cnt0;
        send(8'h66, 1'b1, 1'b0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1 check("cnt0_wrap", pkt_cnt0, 16'h0000);
`endif

        // Packet lock: in_sel toggles after the first beat but the packet stays on out1.
        check("lock_busy_pre", busy, 1'b0);
        send(8'hA1, 1'b0, 1'b1, 1'b1, w);
        check("lock_state_b1", {busy, active_sel}, 2'b11);
        send(8'hA2, 1'b0, 1'b0, 1'b1, w);
        check("lock_state_b2", {busy, active_sel}, 2'b11);
        send(8'hA3, 1'b1, 1'b0, 1'b1, w);
        check("lock_state_b3", {busy, active_sel}, 2'b00);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure on out0.
        out0_ready = 1'b0;
        send(8'h10, 1'b0, 1'b0, 1'b0, w);
        in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1; in_sel = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_hold", {out0_valid, out0_data}, 9'h110);
        end
        @(posedge clk);
        #1 out0_ready = 1'b1;
        send(8'h11, 1'b1, 1'b1, 1'b0, w);
        check("bp_release_waits", w, 0);
        repeat (2) @(posedge clk);
        #1;

        // Independence: out0 stalled on a last beat, next packet goes straight to out1.
        out0_ready = 1'b0;
        send(8'h20, 1'b1, 1'b0, 1'b0, w);
        send(8'h55, 1'b1, 1'b1, 1'b1, w);
        check("indep_waits", w, 0);
        check("indep_out0_held", {out0_valid, out0_last, out0_data}, 10'h320);
        out0_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-packet with a beat stuck in out0.
        out0_ready = 1'b0;
        send(8'h30, 1'b0, 1'b0, 1'b0, w);
        check("midrst_busy", busy, 1'b1);
        rst = 1'b1;
        exp0.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_valid", {out0_valid, out1_valid}, 2'b00);
        check("midrst_state", {busy, active_sel}, 2'b00);
        out0_ready = 1'b1;
        send(8'h40, 1'b1, 1'b1, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;

        check("drain_out0", exp0.size(), 0);
        check("drain_out1", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
